// File: rtl/instr_encoder.sv
// Sequential instruction encoder/loader: packs mnemonic and register-field requests
// into 9-bit words and writes them to instruction memory from address 0 upward.
module instr_encoder #(
  parameter int addr_width  = 8,
  parameter int instr_width = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_op,
  input  logic [3:0]             in_ra,
  input  logic [3:0]             in_rb,
  input  logic [3:0]             in_rc,
  output logic                   im_we,
  output logic [addr_width-1:0]  im_addr,
  output logic [instr_width-1:0] im_wdata,
  output logic [addr_width:0]    word_count,
  output logic                   done,
  output logic                   full,
  output logic                   err_illegal
);

  typedef enum logic {
    ST_LOAD,
    ST_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_SLT  = 4'd1,
    OP_OR   = 4'd2,
    OP_JR   = 4'd3,
    OP_LW   = 4'd4,
    OP_SW   = 4'd5,
    OP_ADD  = 4'd6,
    OP_ADDI = 4'd7,
    OP_SUB  = 4'd8,
    OP_TR   = 4'd9,
    OP_SRL  = 4'd10,
    OP_SRA  = 4'd11,
    OP_SLL  = 4'd12,
    OP_HALT = 4'd13
  } op_e;

  state_e                   state;
  logic [addr_width-1:0]    wr_ptr;
  logic [instr_width-1:0]   enc_word;
  logic                     enc_legal;
  logic                     is_halt;
  logic [3:0]               ra_off;
  logic                     ra_lo, ra_tr, rb_lo, rb_hi, rc_lo, rc_hi, rc_tr;
  logic                     accept;

  assign in_ready = (state == ST_LOAD) && !start && !reset;
  assign accept   = in_valid && in_ready;

  // Register-number offsets are 4-bit subtractions; only the low bits survive
  // once the range check has passed (rb-8 and rc-8 reduce to the low two bits).
  assign ra_off = in_ra - 4'd4;
  assign ra_lo  = (in_ra[3:2] == 2'b01);
  assign ra_tr  = (in_ra >= 4'd4) && (in_ra <= 4'd11);
  assign rb_lo  = (in_rb[3:2] == 2'b00);
  assign rb_hi  = (in_rb[3:2] == 2'b10);
  assign rc_lo  = (in_rc[3:2] == 2'b00);
  assign rc_hi  = (in_rc[3:2] == 2'b10);
  assign rc_tr  = !in_rc[3];
  assign is_halt = (in_op == OP_HALT);

  always_comb begin
    enc_legal = 1'b0;
    enc_word  = '0;
    case (in_op)
      OP_AND, OP_OR, OP_JR: begin
        enc_legal = ra_lo && rb_lo;
        enc_word  = {3'b000, ra_off[1:0], in_rb[1:0], in_op[1:0]};
      end
      OP_SLT: begin
        enc_legal = ra_lo && rb_hi;
        enc_word  = {3'b000, ra_off[1:0], in_rb[1:0], 2'b01};
      end
      OP_LW: begin
        enc_legal = ra_lo && rc_lo;
        enc_word  = {3'b001, ra_off[1:0], in_rc[1:0], 2'b00};
      end
      OP_SW: begin
        enc_legal = ra_lo && rb_lo;
        enc_word  = {3'b001, ra_off[1:0], in_rb[1:0], 2'b01};
      end
      OP_ADD: begin
        enc_legal = ra_lo && rb_lo && rc_hi;
        enc_word  = {3'b010, ra_off[1:0], in_rb[1:0], in_rc[1:0]};
      end
      OP_SUB: begin
        enc_legal = ra_lo && rb_lo && rc_hi;
        enc_word  = {3'b110, ra_off[1:0], in_rb[1:0], in_rc[1:0]};
      end
      OP_ADDI: begin
        enc_legal = ra_lo && rc_lo;
        enc_word  = {3'b011, ra_off[1:0], 2'b00, in_rc[1:0]};
      end
      OP_TR: begin
        enc_legal = ra_tr && rc_tr;
        enc_word  = {3'b100, in_rc[2:0], ra_off[2:0]};
      end
      OP_SRL: begin
        enc_legal = ra_lo && rb_lo;
        enc_word  = {3'b111, ra_off[1:0], in_rb[1:0], 2'b00};
      end
      OP_SRA: begin
        enc_legal = ra_lo && rb_lo;
        enc_word  = {3'b111, ra_off[1:0], in_rb[1:0], 2'b01};
      end
      OP_SLL: begin
        enc_legal = ra_lo && rb_lo;
        enc_word  = {3'b111, ra_off[1:0], in_rb[1:0], 2'b10};
      end
      OP_HALT: begin
        enc_legal = 1'b1;
        enc_word  = 9'b111_00_00_11;
      end
      default: begin
        enc_legal = 1'b0;
        enc_word  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LOAD;
      wr_ptr      <= '0;
      im_we       <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= '0;
      word_count  <= '0;
      done        <= 1'b0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      im_we       <= 1'b0;
      err_illegal <= 1'b0;
      if (start) begin
        state      <= ST_LOAD;
        wr_ptr     <= '0;
        word_count <= '0;
        done       <= 1'b0;
        full       <= 1'b0;
      end else if (accept) begin
        if (enc_legal) begin
          im_we      <= 1'b1;
          im_addr    <= wr_ptr;
          im_wdata   <= enc_word;
          wr_ptr     <= wr_ptr + 1'b1;
          word_count <= word_count + 1'b1;
          // The last address and HALT both end the load; the pointer still wraps.
          if (is_halt || (&wr_ptr)) begin
            state <= ST_DONE;
            done  <= 1'b1;
            full  <= &wr_ptr;
          end
        end else begin
          err_illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized
// stream checked against an arithmetic encoding model; a 4-word instance covers full.
module tb_instr_encoder;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [3:0] in_op, in_ra, in_rb, in_rc;
  logic       in_ready, im_we, done, full, err_illegal;
  logic [7:0] im_addr;
  logic [8:0] im_wdata;
  logic [8:0] word_count;

  logic       start_s, valid_s;
  logic [3:0] op_s, ra_s, rb_s, rc_s;
  logic       ready_s, we_s, done_s, full_s, err_s;
  logic [1:0] addr_s;
  logic [8:0] wdata_s;
  logic [2:0] count_s;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .word_count(word_count),
    .done(done), .full(full), .err_illegal(err_illegal)
  );

  instr_encoder #(.addr_width(2), .instr_width(9)) dut_small (
    .clk(clk), .reset(reset), .start(start_s), .in_valid(valid_s), .in_ready(ready_s),
    .in_op(op_s), .in_ra(ra_s), .in_rb(rb_s), .in_rc(rc_s),
    .im_we(we_s), .im_addr(addr_s), .im_wdata(wdata_s), .word_count(count_s),
    .done(done_s), .full(full_s), .err_illegal(err_s)
  );

  // Encoding computed as opcode*64 + field weights from the published table.
  function automatic void model(input int op, input int ra, input int rb, input int rc,
                                output bit legal, output logic [8:0] word);
    int w;
    bit a_ok;
    a_ok  = (ra >= 4) && (ra <= 7);
    w     = 0;
    legal = 1'b0;
    case (op)
      0, 2, 3:    begin legal = a_ok && rb <= 3; w = (ra-4)*16 + rb*4 + op; end
      1:          begin legal = a_ok && rb >= 8 && rb <= 11; w = (ra-4)*16 + (rb-8)*4 + 1; end
      4:          begin legal = a_ok && rc <= 3; w = 64 + (ra-4)*16 + rc*4; end
      5:          begin legal = a_ok && rb <= 3; w = 64 + (ra-4)*16 + rb*4 + 1; end
      6:          begin legal = a_ok && rb <= 3 && rc >= 8 && rc <= 11; w = 128 + (ra-4)*16 + rb*4 + (rc-8); end
      7:          begin legal = a_ok && rc <= 3; w = 192 + (ra-4)*16 + rc; end
      8:          begin legal = a_ok && rb <= 3 && rc >= 8 && rc <= 11; w = 384 + (ra-4)*16 + rb*4 + (rc-8); end
      9:          begin legal = rc <= 7 && ra >= 4 && ra <= 11; w = 256 + rc*8 + (ra-4); end
      10, 11, 12: begin legal = a_ok && rb <= 3; w = 448 + (ra-4)*16 + rb*4 + (op-10); end
      13:         begin legal = 1'b1; w = 448 + 3; end
      default:    legal = 1'b0;
    endcase
    word = legal ? w[8:0] : 9'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_legal(output logic [3:0] op, output logic [3:0] ra,
                           output logic [3:0] rb, output logic [3:0] rc);
    bit lg;
    logic [8:0] w;
    for (int k = 0; k < 10000; k++) begin
      op = 4'($urandom_range(0, 12));
      ra = 4'($urandom_range(4, 11));
      rb = 4'($urandom_range(0, 11));
      rc = 4'($urandom_range(0, 11));
      model(op, ra, rb, rc, lg, w);
      if (lg) break;
    end
  endtask

  task automatic drive(input int op, input int ra, input int rb, input int rc);
    in_op = op[3:0]; in_ra = ra[3:0]; in_rb = rb[3:0]; in_rc = rc[3:0];
    in_valid = 1'b1;
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    start_s = 1'b0; valid_s = 1'b0;
    in_op = '0; in_ra = '0; in_rb = '0; in_rc = '0;
    op_s = '0; ra_s = '0; rb_s = '0; rc_s = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if ({im_we, im_addr, im_wdata, word_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got we=%0b addr=%0d data=%b count=%0d required all 0", im_we, im_addr, im_wdata, word_count);
    end
    tests_run++;
    if ({done, full, err_illegal} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got done=%0b full=%0b err=%0b required 000", done, full, err_illegal);
    end
    tests_run++;
    if (in_ready !== 1'b1 || ready_s !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %0b/%0b required 1/1", in_ready, ready_s);
    end
  endtask

  task automatic test_add_first();
    drive(6, 5, 2, 9);
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({im_we, im_addr, im_wdata, word_count} !== {1'b1, 8'd0, 9'b010_01_10_01, 9'd1}) begin
      tests_failed++;
      $display("FAIL add_first: got we=%0b addr=%0d data=%b count=%0d required 1 0 010011001 1", im_we, im_addr, im_wdata, word_count);
    end
    tick();
    tests_run++;
    if (im_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_strobe_width: got im_we=%0b required 0", im_we);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    drive(9, 11, 0, 7);
    tick();
    tests_run++;
    if ({im_we, im_addr, im_wdata, word_count} !== {1'b1, 8'd0, 9'b100_111_111, 9'd1}) begin
      tests_failed++;
      $display("FAIL b2b_tr: got we=%0b addr=%0d data=%b count=%0d required 1 0 100111111 1", im_we, im_addr, im_wdata, word_count);
    end
    drive(7, 4, 0, 3);
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({im_we, im_addr, im_wdata, word_count} !== {1'b1, 8'd1, 9'b011_00_00_11, 9'd2}) begin
      tests_failed++;
      $display("FAIL b2b_addi: got we=%0b addr=%0d data=%b count=%0d required 1 1 011000011 2", im_we, im_addr, im_wdata, word_count);
    end
  endtask

  task automatic test_illegal();
    pulse_start();
    drive(1, 6, 3, 0);
    tick();
    tests_run++;
    if ({err_illegal, im_we, word_count} !== {1'b1, 1'b0, 9'd0}) begin
      tests_failed++;
      $display("FAIL illegal_slt: got err=%0b we=%0b count=%0d required 1 0 0", err_illegal, im_we, word_count);
    end
    drive(15, 4, 0, 0);
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({err_illegal, im_we, word_count} !== {1'b1, 1'b0, 9'd0}) begin
      tests_failed++;
      $display("FAIL illegal_op15: got err=%0b we=%0b count=%0d required 1 0 0", err_illegal, im_we, word_count);
    end
    tick();
    tests_run++;
    if (err_illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_pulse: got err=%0b required 0", err_illegal);
    end
    drive(6, 7, 3, 11);
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({im_we, im_addr, im_wdata} !== {1'b1, 8'd0, 9'b010_11_11_11}) begin
      tests_failed++;
      $display("FAIL illegal_ptr_hold: got we=%0b addr=%0d data=%b required 1 0 010111111", im_we, im_addr, im_wdata);
    end
  endtask

  task automatic test_halt();
    logic [3:0] op, ra, rb, rc;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      gen_legal(op, ra, rb, rc);
      drive(op, ra, rb, rc);
      tick();
    end
    drive(13, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    tick();
    tests_run++;
    if ({im_we, im_addr, im_wdata, word_count} !== {1'b1, 8'd3, 9'b111_00_00_11, 9'd4}) begin
      tests_failed++;
      $display("FAIL halt_write: got we=%0b addr=%0d data=%b count=%0d required 1 3 111000011 4", im_we, im_addr, im_wdata, word_count);
    end
    tests_run++;
    if ({done, full, in_ready} !== 3'b100) begin
      tests_failed++;
      $display("FAIL halt_flags: got done=%0b full=%0b ready=%0b required 1 0 0", done, full, in_ready);
    end
    gen_legal(op, ra, rb, rc);
    drive(op, ra, rb, rc);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({im_we, err_illegal, word_count, done} !== {1'b0, 1'b0, 9'd4, 1'b1}) begin
        tests_failed++;
        $display("FAIL halt_ignore: got we=%0b err=%0b count=%0d done=%0b required 0 0 4 1", im_we, err_illegal, word_count, done);
      end
    end
    pulse_start();
    #1;
    tests_run++;
    if ({in_ready, done, word_count} !== {1'b1, 1'b0, 9'd0}) begin
      tests_failed++;
      $display("FAIL halt_restart: got ready=%0b done=%0b count=%0d required 1 0 0", in_ready, done, word_count);
    end
  endtask

  task automatic test_start_collision();
    logic [3:0] op, ra, rb, rc;
    gen_legal(op, ra, rb, rc);
    drive(op, ra, rb, rc);
    tick();
    start = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, im_we} !== 2'b01) begin
      tests_failed++;
      $display("FAIL start_ready: got ready=%0b we=%0b required 0 1", in_ready, im_we);
    end
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if ({im_we, word_count} !== {1'b0, 9'd0}) begin
      tests_failed++;
      $display("FAIL start_collision: got we=%0b count=%0d required 0 0", im_we, word_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] op, ra, rb, rc;
    bit lg;
    logic [8:0] w;
    gen_legal(op, ra, rb, rc);
    drive(op, ra, rb, rc);
    tick();
    gen_legal(op, ra, rb, rc);
    drive(op, ra, rb, rc);
    reset = 1'b1;
    tick();
    tests_run++;
    if ({im_we, im_addr, im_wdata, word_count, done, full, err_illegal} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: got we=%0b addr=%0d data=%b count=%0d required all 0", im_we, im_addr, im_wdata, word_count);
    end
    reset = 1'b0;
    gen_legal(op, ra, rb, rc);
    model(op, ra, rb, rc, lg, w);
    drive(op, ra, rb, rc);
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({im_we, im_addr, im_wdata, word_count} !== {1'b1, 8'd0, w, 9'd1}) begin
      tests_failed++;
      $display("FAIL reset_resume: got we=%0b addr=%0d data=%b count=%0d required 1 0 %b 1", im_we, im_addr, im_wdata, word_count, w);
    end
  endtask

  task automatic test_random_stream();
    logic [3:0] op, ra, rb, rc;
    bit lg, vld;
    logic [8:0] w;
    int ptr;
    pulse_start();
    ptr = 0;
    for (int i = 0; i < 200; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 7) gen_legal(op, ra, rb, rc);
      else begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd13) op = 4'd14;
        ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      end
      model(op, ra, rb, rc, lg, w);
      drive(op, ra, rb, rc);
      in_valid = vld;
      tick();
      if (vld && lg) ptr++;
      tests_run++;
      if ({im_we, err_illegal, word_count} !== {vld && lg, vld && !lg, 9'(ptr)}) begin
        tests_failed++;
        $display("FAIL rand_ctrl[%0d]: got we=%0b err=%0b count=%0d required %0b %0b %0d", i, im_we, err_illegal, word_count, vld && lg, vld && !lg, ptr);
      end
      if (vld && lg) begin
        tests_run++;
        if ({im_addr, im_wdata} !== {8'(ptr - 1), w}) begin
          tests_failed++;
          $display("FAIL rand_word[%0d]: got addr=%0d data=%b required %0d %b (op=%0d ra=%0d rb=%0d rc=%0d)", i, im_addr, im_wdata, ptr - 1, w, op, ra, rb, rc);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full();
    logic [3:0] op, ra, rb, rc;
    bit lg;
    logic [8:0] w;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gen_legal(op, ra, rb, rc);
      model(op, ra, rb, rc, lg, w);
      op_s = op; ra_s = ra; rb_s = rb; rc_s = rc; valid_s = 1'b1;
      tick();
      tests_run++;
      if ({we_s, addr_s, wdata_s, count_s} !== {1'b1, 2'(i), w, 3'(i + 1)}) begin
        tests_failed++;
        $display("FAIL full_write[%0d]: got we=%0b addr=%0d data=%b count=%0d required 1 %0d %b %0d", i, we_s, addr_s, wdata_s, count_s, i, w, i + 1);
      end
    end
    tests_run++;
    if ({full_s, done_s, ready_s} !== 3'b110) begin
      tests_failed++;
      $display("FAIL full_flags: got full=%0b done=%0b ready=%0b required 1 1 0", full_s, done_s, ready_s);
    end
    gen_legal(op, ra, rb, rc);
    op_s = op; ra_s = ra; rb_s = rb; rc_s = rc;
    tick();
    valid_s = 1'b0;
    tests_run++;
    if ({we_s, count_s, full_s} !== {1'b0, 3'd4, 1'b1}) begin
      tests_failed++;
      $display("FAIL full_fifth: got we=%0b count=%0d full=%0b required 0 4 1", we_s, count_s, full_s);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_first();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_start_collision();
    test_reset_mid();
    test_random_stream();
    test_full();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and loader that packs mnemonic/register-field requests into 9-bit machine words and streams them into instruction memory. It is the write-side counterpart of the instruction decoder: every word it emits decodes back to the requested operation and register numbers. It sits between the test/boot harness and instruction memory, loading programs sequentially from address 0 until HALT or memory full.

## Interface
Parameters:
- addr_width, 8, instruction-memory address width; depth = 2**addr_width
- instr_width, 9, emitted word width (fixed encoding below)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse: clear address/count/flags, enter LOAD
- in_valid  in  1  request valid
- in_ready  out  1  = (state==LOAD) && !start (combinational)
- in_op  in  4  mnemonic: 0 AND,1 SLT,2 OR,3 JR,4 LW,5 SW,6 ADD,7 ADDI,8 SUB,9 TR,10 SRL,11 SRA,12 SLL,13 HALT,14-15 illegal
- in_ra  in  4  architectural register A (source/address reg)
- in_rb  in  4  architectural register B (second source)
- in_rc  in  4  destination register or 2-bit immediate
- im_we  out  1  instruction-memory write strobe
- im_addr  out  addr_width  write address
- im_wdata  out  9  encoded word
- word_count  out  addr_width+1  words written since start/reset
- done  out  1  level: HALT written or memory full
- full  out  1  level: word written at address depth-1
- err_illegal  out  1  one-cycle pulse on rejected request

## Operation
- States: LOAD, DONE. Reset -> LOAD, all outputs 0 (in_ready=1 once reset deasserts).
- Accept when in_valid && in_ready. Legal request: registered word to im_wdata, im_addr = current write pointer, im_we=1 next cycle; pointer and word_count +1.
- Illegal request (bad in_op or any checked field out of range): no write, pointer unchanged, err_illegal=1 next cycle, stay LOAD.
- Encoding, word = op[8:6] | f[5:4] | f[3:2] | f[1:0]:
  - AND/SLT/OR/JR: 000, ra-4, B, subop 00/01/10/11; ra in 4..7; B=rb (0..3) except SLT B=rb-8 (rb in 8..11).
  - LW: 001, ra-4, rc (0..3), 00. SW: 001, ra-4, rb (0..3), 01.
  - ADD/SUB: 010/110, ra-4, rb (0..3), rc-8 (rc in 8..11).
  - ADDI: 011, ra-4, 00, rc (immediate 0..3).
  - TR: 100, [5:3]=rc (0..7), [2:0]=ra-4 (ra in 4..11).
  - SRL/SRA/SLL: 111, ra-4, rb (0..3), subop 00/01/10.
  - HALT: 9'b111_00_00_11; ra/rb/rc ignored.
- Unused fields never checked. Subtraction performed in 4 bits, low bits taken after range check.
- HALT accepted: written like any word, then -> DONE, done=1.
- Legal word accepted while pointer == depth-1: written, then -> DONE, full=1, done=1; pointer wraps to 0 but no further writes.
- DONE: in_ready=0, in_valid ignored; only start or reset leaves.
- start (any state): pointer=0, word_count=0, done=full=0, -> LOAD next cycle; a request presented the same cycle is not accepted (in_ready=0). A write already registered from the prior cycle still completes.
- reset mid-load: im_we dropped same edge; pending write lost.

## Timing
- Latency: accept on edge N -> im_we/im_addr/im_wdata valid during cycle N+1 (one cycle), single-cycle strobe.
- Throughput: one word per cycle in LOAD.
- err_illegal asserted in cycle N+1, exactly one cycle per rejected request.
- done/full rise in cycle N+1 with the final write; in_ready low from that cycle.
- word_count reflects the write in cycle N+1.

## Test plan
- ADD ra=5 rb=2 rc=9 at reset -> next cycle im_we=1, im_addr=0, im_wdata=9'b010_01_10_01, word_count=1.
- Back-to-back TR ra=11 rc=7 then ADDI ra=4 rc=3 -> addr 0: 9'b100_111_111, addr 1: 9'b011_00_00_11, consecutive cycles.
- SLT ra=6 rb=3 (illegal rb) and in_op=15 -> err_illegal pulse each, no im_we, pointer stays.
- HALT after 3 words -> im_addr=3, im_wdata=9'b111000011, done=1, in_ready=0; later valid requests ignored; start -> LOAD, word_count=0.
- addr_width=2: four legal words -> 4th at addr 3, full=1, done=1, word_count=4, fifth request not accepted.
- start asserted with in_valid in LOAD -> no write that cycle; reset during stream -> im_we=0, all outputs 0, next accepted word at addr 0.
